// File: rtl/dmem_mmio_pkg.sv
// Shared definitions for the data-memory / MMIO controller:
// FSM state encoding, MMIO register addresses and STATUS bit positions.
package dmem_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        TX_STALL = 2'd2
    } state_t;

    localparam logic [31:0] MMIO_TX_ADDR     = 32'h8000_0000;
    localparam logic [31:0] MMIO_STATUS_ADDR = 32'h8000_0004;
    localparam logic [31:0] MMIO_RX_ADDR     = 32'h8000_0008;

    localparam int unsigned STAT_TX_FULL    = 0;
    localparam int unsigned STAT_TX_EMPTY   = 1;
    localparam int unsigned STAT_RX_VALID   = 2;
    localparam int unsigned STAT_RX_OVERRUN = 3;

endpackage

// File: rtl/dmem_mmio_ctrl_fifo.sv
// byte_fifo: power-of-two deep byte FIFO feeding the UART transmitter.
// Push is refused when full, pop is refused when empty; full/empty come
// from the registered occupancy count.
module byte_fifo
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       Rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// dmem_mmio_ctrl: routes core loads/stores to a 1-cycle-latency data RAM
// or to memory-mapped UART registers (TX FIFO, STATUS, optional RX).
// Optional feature macro: MMIO_RX_EN (adds rx ports and RX data register).
module dmem_mmio_ctrl
    import dmem_mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RAM_AW     = 12
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic [3:0]        mem_en,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_din,
    input  logic              mem_wea,
    input  logic              mem_rea,
    output logic [31:0]       mem_dout,
    output logic              mem_hold,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
`ifdef MMIO_RX_EN
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
`endif
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state;
    state_t        state_nx;
    logic          is_ram;
    logic          is_tx;
    logic          is_stat;
    logic          is_rx;
    logic          tx_write;
    logic          tx_push;
    logic          tx_pop;
    logic          tx_full;
    logic          tx_full_q;
    logic          tx_empty;
    logic [CW-1:0] tx_count;
    logic [31:0]   status;
    logic          stat_rd;
`ifdef MMIO_RX_EN
    logic [7:0]    rx_reg;
    logic          rx_flag;
    logic          rx_ovr;
    logic          rx_rd;
`endif

    assign is_ram   = !mem_addr[31];
    assign is_tx    = (mem_addr == MMIO_TX_ADDR);
    assign is_stat  = (mem_addr == MMIO_STATUS_ADDR);
    assign is_rx    = (mem_addr == MMIO_RX_ADDR);
    assign tx_write = mem_wea && is_tx && mem_en[0];
    assign ram_addr = mem_addr[RAM_AW+1:2];
    assign ram_din  = mem_din;
    // Stall decisions use the registered occupancy, so a pop in the same
    // cycle does not unblock a push until the next cycle.
    assign tx_full_q = (tx_count == CW'(FIFO_DEPTH));
    assign tx_valid  = !tx_empty && !Rst;
    assign tx_pop    = tx_valid && tx_ready;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (mem_din[7:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    // STATUS register image.
    always_comb begin
        status = '0;
        status[STAT_TX_FULL]  = tx_full;
        status[STAT_TX_EMPTY] = tx_empty;
`ifdef MMIO_RX_EN
        status[STAT_RX_VALID]   = rx_flag;
        status[STAT_RX_OVERRUN] = rx_ovr;
`endif
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (is_ram && mem_rea && !mem_wea) state_nx = RD_WAIT;
                else if (tx_write && tx_full_q)    state_nx = TX_STALL;
            end
            RD_WAIT:  state_nx = IDLE;
            TX_STALL: if (!tx_full_q) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // FSM outputs: RAM strobes, core hold/data, FIFO push, read side effects.
    always_comb begin
        mem_hold = 1'b0;
        mem_dout = '0;
        ram_en   = 1'b0;
        ram_we   = '0;
        tx_push  = 1'b0;
        stat_rd  = 1'b0;
`ifdef MMIO_RX_EN
        rx_rd    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (is_ram) begin
                    if (mem_wea) begin
                        ram_en = 1'b1;
                        ram_we = mem_en;
                    end else if (mem_rea) begin
                        ram_en   = 1'b1;
                        mem_hold = 1'b1;
                    end
                end else begin
                    if (tx_write) begin
                        if (tx_full_q) mem_hold = 1'b1;
                        else           tx_push  = 1'b1;
                    end
                    if (mem_rea && !mem_wea) begin
                        if (is_stat) begin
                            mem_dout = status;
                            stat_rd  = 1'b1;
                        end
`ifdef MMIO_RX_EN
                        if (is_rx) begin
                            mem_dout = {24'd0, rx_reg};
                            rx_rd    = 1'b1;
                        end
`else
                        if (is_rx) mem_dout = '0;
`endif
                    end
                end
            end
            RD_WAIT: mem_dout = ram_dout;
            TX_STALL: begin
                if (tx_full_q) mem_hold = 1'b1;
                else           tx_push  = 1'b1;
            end
            default: ;
        endcase
        // Reset overrides everything so an in-flight operation is dropped.
        if (Rst) begin
            mem_hold = 1'b0;
            mem_dout = '0;
            ram_en   = 1'b0;
            ram_we   = '0;
            tx_push  = 1'b0;
            stat_rd  = 1'b0;
`ifdef MMIO_RX_EN
            rx_rd    = 1'b0;
`endif
        end
    end

`ifdef MMIO_RX_EN
    // RX byte capture with valid/overrun flags; a new strobe beats a clear.
    always_ff @(posedge clk) begin
        if (Rst) begin
            rx_reg  <= '0;
            rx_flag <= 1'b0;
            rx_ovr  <= 1'b0;
        end else begin
            if (rx_valid) begin
                rx_reg  <= rx_data;
                rx_flag <= 1'b1;
            end else if (rx_rd) begin
                rx_flag <= 1'b0;
            end
            if (rx_valid && rx_flag) rx_ovr <= 1'b1;
            else if (stat_rd)        rx_ovr <= 1'b0;
        end
    end
`else
    // Without the RX block, STATUS reads have no side effect.
    logic stat_rd_unused;
    assign stat_rd_unused = stat_rd;
`endif

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Directed, table-driven bench for dmem_mmio_ctrl (FIFO_DEPTH=8).
module tb_dmem_mmio_ctrl;

    localparam logic [31:0] TXA = 32'h8000_0000;
    localparam logic [31:0] STA = 32'h8000_0004;
    localparam logic [31:0] RXA = 32'h8000_0008;

    logic        clk = 1'b0;
    logic        Rst;
    logic [3:0]  mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic        mem_wea;
    logic        mem_rea;
    logic [31:0] mem_dout;
    logic        mem_hold;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [11:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
`ifdef MMIO_RX_EN
    logic [7:0]  rx_data;
    logic        rx_valid;
`endif

    int unsigned n_vec  = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    dmem_mmio_ctrl #(
        .FIFO_DEPTH (8),
        .RAM_AW     (12)
    ) dut (
        .clk      (clk),
        .Rst      (Rst),
        .mem_en   (mem_en),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_wea  (mem_wea),
        .mem_rea  (mem_rea),
        .mem_dout (mem_dout),
        .mem_hold (mem_hold),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
`ifdef MMIO_RX_EN
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
`endif
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    // Behavioural RAM with one-cycle read latency.
    logic [31:0] ram_model [4096];
    initial begin
        for (int i = 0; i < 4096; i++) ram_model[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram_model[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            ram_dout <= ram_model[ram_addr];
        end
    end

    typedef struct {
        logic        rst;
        logic        rea;
        logic        wea;
        logic [3:0]  en;
        logic [31:0] addr;
        logic [31:0] din;
        logic        rdy;
        logic        hold;
        logic [31:0] dout;
        logic        ren;
        logic [3:0]  rwe;
        logic        txv;
        logic [7:0]  txd;
    } vec_t;

    function automatic vec_t mk(logic rst, logic rea, logic wea, logic [3:0] en,
                                logic [31:0] addr, logic [31:0] din, logic rdy,
                                logic hold, logic [31:0] dout, logic ren,
                                logic [3:0] rwe, logic txv, logic [7:0] txd);
        vec_t v;
        v.rst = rst; v.rea = rea; v.wea = wea; v.en = en; v.addr = addr;
        v.din = din; v.rdy = rdy; v.hold = hold; v.dout = dout; v.ren = ren;
        v.rwe = rwe; v.txv = txv; v.txd = txd;
        return v;
    endfunction

    // Drive one cycle of inputs, check outputs mid-cycle, advance past the edge.
    task automatic apply(input string name, input vec_t v);
        Rst      = v.rst;
        mem_rea  = v.rea;
        mem_wea  = v.wea;
        mem_en   = v.en;
        mem_addr = v.addr;
        mem_din  = v.din;
        tx_ready = v.rdy;
        @(negedge clk);
        n_vec++;
        if (mem_hold !== v.hold || mem_dout !== v.dout || ram_en !== v.ren ||
            ram_we !== v.rwe || tx_valid !== v.txv ||
            (v.txv && tx_data !== v.txd)) begin
            n_fail++;
            $display("FAIL %s: got hold=%b dout=%h ram_en=%b ram_we=%b tx_valid=%b tx_data=%h; want hold=%b dout=%h ram_en=%b ram_we=%b tx_valid=%b tx_data=%h",
                     name, mem_hold, mem_dout, ram_en, ram_we, tx_valid, tx_data,
                     v.hold, v.dout, v.ren, v.rwe, v.txv, v.txd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] want);
        n_vec++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    vec_t        tbl[$];
    logic [7:0]  got_q[$];
    int unsigned cyc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Rst = 1'b1; mem_rea = 0; mem_wea = 0; mem_en = '0; mem_addr = '0;
        mem_din = '0; tx_ready = 0;
`ifdef MMIO_RX_EN
        rx_data = '0; rx_valid = 1'b0;
`endif
        //                rst rea wea en      addr        din           rdy hold dout          ren rwe     txv txd
        tbl.push_back(mk(1, 1, 0, 4'h0, 32'h10,     32'h0,        0, 0, 32'h0,        0, 4'h0, 0, 8'h00)); // 0 reset gates load
        tbl.push_back(mk(1, 0, 1, 4'h1, TXA,        32'h77,       0, 0, 32'h0,        0, 4'h0, 0, 8'h00)); // 1 reset gates tx
        tbl.push_back(mk(0, 1, 0, 4'hF, STA,        32'h0,        0, 0, 32'h2,        0, 4'h0, 0, 8'h00)); // 2 status after reset
        tbl.push_back(mk(0, 0, 1, 4'hF, 32'h10,     32'hDEADBEEF, 0, 0, 32'h0,        1, 4'hF, 0, 8'h00)); // 3 word store
        tbl.push_back(mk(0, 1, 0, 4'hF, 32'h10,     32'h0,        0, 1, 32'h0,        1, 4'h0, 0, 8'h00)); // 4 load, hold
        tbl.push_back(mk(0, 1, 0, 4'hF, 32'h10,     32'h0,        0, 0, 32'hDEADBEEF, 0, 4'h0, 0, 8'h00)); // 5 load data
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h0,      32'h0,        0, 0, 32'h0,        0, 4'h0, 0, 8'h00)); // 6 idle
        tbl.push_back(mk(0, 0, 1, 4'h4, 32'h12,     32'h00AB0000, 0, 0, 32'h0,        1, 4'h4, 0, 8'h00)); // 7 byte store
        tbl.push_back(mk(0, 1, 0, 4'hF, 32'h10,     32'h0,        0, 1, 32'h0,        1, 4'h0, 0, 8'h00)); // 8
        tbl.push_back(mk(0, 1, 0, 4'hF, 32'h10,     32'h0,        0, 0, 32'hDEABBEEF, 0, 4'h0, 0, 8'h00)); // 9 merged word
        tbl.push_back(mk(0, 0, 1, 4'h1, TXA,        32'h01,       0, 0, 32'h0,        0, 4'h0, 0, 8'h00)); // 10 tx 1
        tbl.push_back(mk(0, 0, 1, 4'h1, TXA,        32'h02,       0, 0, 32'h0,        0, 4'h0, 1, 8'h01)); // 11 tx 2
        tbl.push_back(mk(0, 0, 1, 4'h1, TXA,        32'h03,       0, 0, 32'h0,        0, 4'h0, 1, 8'h01)); // 12 tx 3
        tbl.push_back(mk(0, 1, 0, 4'hF, STA,        32'h0,        0, 0, 32'h0,        0, 4'h0, 1, 8'h01)); // 13 status 3 entries
        tbl.push_back(mk(0, 0, 1, 4'h2, TXA,        32'h55,       0, 0, 32'h0,        0, 4'h0, 1, 8'h01)); // 14 tx en[0]=0 ignored
        tbl.push_back(mk(0, 1, 0, 4'hF, 32'h80000010, 32'h0,      0, 0, 32'h0,        0, 4'h0, 1, 8'h01)); // 15 unmapped read
        tbl.push_back(mk(0, 0, 1, 4'hF, 32'h8000000C, 32'hFF,     0, 0, 32'h0,        0, 4'h0, 1, 8'h01)); // 16 unmapped write
        tbl.push_back(mk(0, 1, 1, 4'hF, 32'h20,     32'h12345678, 0, 0, 32'h0,        1, 4'hF, 1, 8'h01)); // 17 rea+wea = store
        tbl.push_back(mk(0, 1, 0, 4'hF, 32'h20,     32'h0,        0, 1, 32'h0,        1, 4'h0, 1, 8'h01)); // 18
        tbl.push_back(mk(0, 1, 0, 4'hF, 32'h20,     32'h0,        0, 0, 32'h12345678, 0, 4'h0, 1, 8'h01)); // 19
        tbl.push_back(mk(0, 1, 0, 4'hF, RXA,        32'h0,        0, 0, 32'h0,        0, 4'h0, 1, 8'h01)); // 20 rx data empty
        for (int i = 4; i <= 8; i++)
            tbl.push_back(mk(0, 0, 1, 4'h1, TXA, i, 0, 0, 32'h0, 0, 4'h0, 1, 8'h01));                   // 21-25 tx 4..8
        tbl.push_back(mk(0, 1, 0, 4'hF, STA,        32'h0,        0, 0, 32'h1,        0, 4'h0, 1, 8'h01)); // 26 status full
        tbl.push_back(mk(0, 0, 1, 4'h1, TXA,        32'h09,       0, 1, 32'h0,        0, 4'h0, 1, 8'h01)); // 27 9th store holds
        tbl.push_back(mk(0, 0, 1, 4'h1, TXA,        32'h09,       0, 1, 32'h0,        0, 4'h0, 1, 8'h01)); // 28 still stalled
        tbl.push_back(mk(0, 0, 1, 4'h1, TXA,        32'h09,       1, 1, 32'h0,        0, 4'h0, 1, 8'h01)); // 29 pop, still held
        tbl.push_back(mk(0, 0, 1, 4'h1, TXA,        32'h09,       0, 0, 32'h0,        0, 4'h0, 1, 8'h02)); // 30 release
        tbl.push_back(mk(0, 0, 0, 4'h0, 32'h0,      32'h0,        0, 0, 32'h0,        0, 4'h0, 1, 8'h02)); // 31 idle

        @(posedge clk);
        #1;
        for (int unsigned i = 0; i < tbl.size(); i++)
            apply($sformatf("vec%0d", i), tbl[i]);

        // Drain the remaining bytes; expect 2..9 in order.
        Rst = 0; mem_rea = 0; mem_wea = 0; tx_ready = 1;
        cyc = 0;
        while (got_q.size() < 8 && cyc < 40) begin
            @(negedge clk);
            if (tx_valid) got_q.push_back(tx_data);
            @(posedge clk);
            #1;
            cyc++;
        end
        tx_ready = 0;
        if (got_q.size() < 8) begin
            n_vec++;
            n_fail++;
            $display("FAIL drain: got %0d bytes want 8 within budget", got_q.size());
        end
        for (int i = 0; i < got_q.size(); i++)
            check_byte($sformatf("drain%0d", i), got_q[i], 8'(i + 2));
        apply("status_drained", mk(0, 1, 0, 4'hF, STA, 32'h0, 0, 0, 32'h2, 0, 4'h0, 0, 8'h00));

        // Reset while stalled on a full FIFO.
        for (int i = 0; i < 8; i++)
            apply($sformatf("fill%0d", i), mk(0, 0, 1, 4'h1, TXA, 32'h10 + i, 0, 0, 32'h0, 0, 4'h0, i != 0, 8'h10));
        apply("stall_a", mk(0, 0, 1, 4'h1, TXA, 32'h18, 0, 1, 32'h0, 0, 4'h0, 1, 8'h10));
        apply("stall_b", mk(0, 0, 1, 4'h1, TXA, 32'h18, 0, 1, 32'h0, 0, 4'h0, 1, 8'h10));
        apply("rst_held", mk(1, 0, 1, 4'h1, TXA, 32'h18, 0, 0, 32'h0, 0, 4'h0, 0, 8'h00));
        apply("post_rst", mk(0, 1, 0, 4'hF, STA, 32'h0, 0, 0, 32'h2, 0, 4'h0, 0, 8'h00));
        apply("post_rst_idle", mk(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 4'h0, 0, 8'h00));

`ifdef MMIO_RX_EN
        // Two RX bytes with no read between: valid + overrun.
        rx_data = 8'h41; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_data = 8'h42;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        apply("rx_status", mk(0, 1, 0, 4'hF, STA, 32'h0, 0, 0, 32'hE, 0, 4'h0, 0, 8'h00));
        apply("rx_data", mk(0, 1, 0, 4'hF, RXA, 32'h0, 0, 0, 32'h42, 0, 4'h0, 0, 8'h00));
        apply("rx_status2", mk(0, 1, 0, 4'hF, STA, 32'h0, 0, 0, 32'h2, 0, 4'h0, 0, 8'h00));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_ctrl.md
DMEM_MMIO_CTRL -- requirements
Module: dmem_mmio_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: TX FIFO entries, a power of 2, at least 2.
REQ-002 SHALL have parameter RAM_AW, default 12: data-RAM word-address width.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge; one clock only.
REQ-004 SHALL have port Rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have core ports: mem_en (in, 4, byte enables), mem_addr (in, 32), mem_din (in, 32), mem_wea (in, 1, store), mem_rea (in, 1, load).
REQ-006 SHALL have core return ports: mem_dout (out, 32, load data) and mem_hold (out, 1, pipeline stall).
REQ-007 SHALL have RAM ports: ram_en (out, 1), ram_we (out, 4), ram_addr (out, RAM_AW), ram_din (out, 32), ram_dout (in, 32; read latency 1 clk).
REQ-008 SHALL have UART TX ports: tx_data (out, 8), tx_valid (out, 1), tx_ready (in, 1); a byte transfers when tx_valid and tx_ready are both high.
REQ-009 SHALL have rx_data (in, 8) and rx_valid (in, 1, one-cycle strobe) only when MMIO_RX_EN is defined.

Function
REQ-010 SHALL decode mem_addr[31]=0 as RAM, word index mem_addr[RAM_AW+1:2].
REQ-011 SHALL decode MMIO addresses: 0x8000_0000 TX data (write-only), 0x8000_0004 STATUS (read-only), 0x8000_0008 RX data (read-only, present only with the macro).
REQ-012 SHALL define STATUS as bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_overrun; all other bits 0.
REQ-013 SHALL implement FSM states IDLE, RD_WAIT and TX_STALL.
REQ-014 SHALL, in IDLE on a RAM load (mem_rea=1), drive ram_en=1 and ram_we=0, assert mem_hold combinationally, and go to RD_WAIT.
REQ-015 SHALL, in RD_WAIT, drive mem_hold=0 and mem_dout=ram_dout, then return to IDLE; any request present in that cycle is the same load and is not re-issued.
REQ-016 SHALL complete a RAM store in one cycle with no hold: ram_en=1, ram_we=mem_en, ram_din=mem_din.
REQ-017 SHALL complete MMIO reads in the same cycle, combinationally, with no hold.
REQ-018 SHALL return 0 for unmapped MMIO reads and ignore unmapped MMIO writes.
REQ-019 SHALL push mem_din[7:0] to the TX FIFO on a store to TX data with mem_en[0]=1; if mem_en[0]=0 the store is ignored.
REQ-020 SHALL, on a TX store while the FIFO is full, assert mem_hold and enter TX_STALL.
REQ-021 SHALL stay in TX_STALL until not full, then push the byte, drive mem_hold=0 in that cycle, and return to IDLE.
REQ-022 SHALL evaluate full from the registered count: a push is blocked when full even if a pop occurs in the same cycle, costing one extra stall cycle.
REQ-023 SHALL drive tx_valid = !empty, with tx_data at the FIFO head.
REQ-024 SHALL handle a simultaneous push and pop on a non-full, non-empty FIFO with the count unchanged.
REQ-025 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and keep the count in clog2(FIFO_DEPTH)+1 bits.
REQ-026 SHALL treat a request with both mem_rea and mem_wea high as a store.

Reset
REQ-027 SHALL, when Rst=1 at a clock edge, set state to IDLE, empty the FIFO, and clear the RX register and both RX flags.
REQ-028 SHALL abandon any in-flight load or stalled store when Rst is asserted mid-operation; no byte is pushed.
REQ-029 SHALL drive these output values while Rst is held: mem_hold=0, mem_dout=0, tx_valid=0, ram_en=0, ram_we=0.

Configuration
REQ-030 SHALL, with MMIO_RX_EN defined, latch rx_data into the RX register on rx_valid and set the rx_valid flag.
REQ-031 SHALL clear the rx_valid flag on a read of RX data; an rx_valid strobe in the same cycle wins.
REQ-032 SHALL, with MMIO_RX_EN defined, set rx_overrun when rx_valid arrives with the flag already set, and clear it on a STATUS read.
REQ-033 SHALL, without MMIO_RX_EN, omit the rx ports, read 0x8000_0008 as 0, and read STATUS bits 2 and 3 as 0.

Structure
REQ-034 SHALL place in package dmem_mmio_pkg: the FSM state enum, the MMIO address constants, and the STATUS bit-position constants.
REQ-035 SHALL implement the TX FIFO as sub-module byte_fifo, with ports push, pop, din, dout, full, empty and count.

Verification
REQ-036 SHALL test a store of 0xDEADBEEF with mem_en=4'hF to 0x10, then a load of 0x10: mem_hold=1 for exactly one cycle and mem_dout=0xDEADBEEF in the following cycle.
REQ-037 SHALL test a store to 0x12 with mem_en=4'b0100, data 0x00AB0000: ram_we=4'b0100; a later load returns the old word with byte 2 = 0xAB.
REQ-038 SHALL test 9 TX stores with tx_ready=0 and FIFO_DEPTH=8: the 9th store holds; raising tx_ready for 1 cycle releases the hold 1 cycle later; output order is 1..9.
REQ-039 SHALL test STATUS reads: 0x2 after reset, 0x1 when the FIFO is full, and 0x0 with 3 entries.
REQ-040 SHALL test, with MMIO_RX_EN defined, rx bytes 0x41 then 0x42 with no read in between: STATUS reads 0xE, then RX data reads 0x42, then STATUS reads 0x2.
REQ-041 SHALL test asserting Rst during TX_STALL: the next cycle has mem_hold=0, tx_valid=0, and STATUS reads 0x2.
